stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Parametrised hardware stack replacing the fixed stack-pointer/memory pair in the processor datapath.
- Supports push, pop and replace-top, with selectable growth direction.
- Provides a registered top-of-stack, an occupancy count, full/empty status, and sticky overflow/underflow error flags.
- Used for call/return linkage and data stacking. The datapath presents one operation per cycle and reads the top-of-stack one cycle later.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of entries. Must be a power of two, at least 2.
- AW, clog2(DEPTH), address width. Derived; do not override.
- GROW_DOWN, 1, direction of growth. 1: first entry at address DEPTH-1, addresses descending. 0: first entry at address 0, addresses ascending.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- op  input  2  operation: 0 none, 1 push, 2 pop, 3 replace-top.
- din  input  WIDTH  data for push and replace.
- clr_err  input  1  clears the ovf and udf flags.
- top  output  WIDTH  registered top-of-stack value; 0 when empty.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ack  output  1  registered one-cycle pulse: the previous cycle's op was accepted.
- ovf  output  1  sticky: a push was attempted while full.
- udf  output  1  sticky: a pop or replace was attempted while empty.

Behaviour:
- Reset:
  - Sampled at posedge clk; reset==0 forces count=0, top=0, ack=0, ovf=0, udf=0.
  - Storage array is not cleared.
  - Reset overrides any op or clr_err in the same cycle.
- Addressing, with c = current count:
  - Next-free address = GROW_DOWN ? DEPTH-1-c : c.
  - Top address = GROW_DOWN ? DEPTH-c : c-1.
  - All address arithmetic is AW bits, modulo DEPTH. No access occurs at an out-of-range address, because rejected ops perform no write.
- op=0: no state change; ack=0 next cycle.
- Push, not full:
  - Write din to the next-free address; count+1; top<=din; ack=1.
- Push, full:
  - Rejected. No write; count and top unchanged; ovf<=1; ack=0.
- Pop, count>=2:
  - count-1; top <= the entry below the current top, read combinationally from the array in the same cycle; ack=1.
- Pop, count==1:
  - count<=0; top<=0; ack=1.
- Pop, empty:
  - Rejected. udf<=1; ack=0; state unchanged.
- Replace-top, not empty:
  - Write din over the current top address; top<=din; count unchanged; ack=1.
- Replace-top, empty:
  - Rejected. udf<=1; no write; ack=0.
- Latency: top, count, empty and full reflect an op on the cycle after the edge that samples it. Back-to-back ops every cycle are supported with no bubbles.
- empty and full are decoded from the count register. Exactly one of them is set at the extremes; neither is set otherwise.
- clr_err: clears ovf and udf. If a new error occurs in the same cycle, the set wins for that flag; the other flag still clears.
- ack is never held for more than one cycle per accepted op.
- Write-then-read on the same address in consecutive cycles must return the new data (push, then pop, then pop across a just-written entry).

Test Plan:
- WIDTH=16, DEPTH=4, GROW_DOWN=1. Release reset, then push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles:
  - count steps 1,2,3,4; top follows each pushed value; ack=1 each cycle; full=1 after the 4th push; empty=0 throughout.
- From full, push 0x5555:
  - ovf=1, ack=0, count=4, top=0x4444.
  - Then pop: top=0x3333, count=3, full=0, ovf still 1.
- Pop three more times, then pop once more:
  - top goes 0x2222, 0x1111, then 0 with count=0 and empty=1.
  - The final pop gives udf=1, ack=0, count=0.
- Replace-top on empty with 0x9999:
  - udf=1, count=0, top=0.
  - Then push 0xAAAA and replace-top with 0xBBBB: top=0xBBBB, count=1.
  - Then pop: count=0, top=0.
- Error clearing:
  - With full and ovf=1, assert clr_err together with a push: ovf stays 1 and udf clears.
  - Next cycle, clr_err alone: ovf=0.
- Reset and direction:
  - Drive reset=0 in the same cycle as a push while count=2: next cycle count=0, top=0, ack=0, flags 0.
  - Repeat test 1 with GROW_DOWN=0: identical port-level results.

Source files
------------

// File: rtl/stack_engine.sv
// Parametrised hardware stack with push, pop and replace-top, selectable growth
// direction, registered top-of-stack, occupancy count and sticky error flags.
module stack_engine #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter bit GROW_DOWN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ack,
  output logic             ovf,
  output logic             udf
);

  localparam logic [1:0]    OP_NONE    = 2'd0;
  localparam logic [1:0]    OP_PUSH    = 2'd1;
  localparam logic [1:0]    OP_POP     = 2'd2;
  localparam logic [1:0]    OP_REPLACE = 2'd3;

  localparam logic [AW:0]   COUNT_ZERO = '0;
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [AW-1:0]    countLow;
  logic [AW-1:0]    freeAddr;
  logic [AW-1:0]    topAddr;
  logic [AW-1:0]    belowAddr;
  logic             isEmpty;
  logic             isFull;
  logic             wrEn;
  logic [AW-1:0]    wrAddr;

  // Addresses are AW bits wide and wrap modulo DEPTH; the wrapped values are
  // only ever used when the operation is legal for the current count.
  assign countLow  = count_q[AW-1:0];
  assign freeAddr  = GROW_DOWN ? (ADDR_LAST - countLow) : countLow;
  assign topAddr   = GROW_DOWN ? (ADDR_LAST - countLow + ADDR_ONE) : (countLow - ADDR_ONE);
  assign belowAddr = GROW_DOWN ? (topAddr + ADDR_ONE) : (topAddr - ADDR_ONE);

  assign isEmpty = (count_q == COUNT_ZERO);
  assign isFull  = (count_q == COUNT_FULL);

  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    ack_d   = 1'b0;
    ovf_d   = ovf_q & ~clr_err;
    udf_d   = udf_q & ~clr_err;
    wrEn    = 1'b0;
    wrAddr  = freeAddr;

    case (op)
      OP_NONE: begin
      end
      OP_PUSH: begin
        if (isFull) begin
          ovf_d = 1'b1;
        end else begin
          wrEn    = 1'b1;
          wrAddr  = freeAddr;
          count_d = count_q + COUNT_ONE;
          top_d   = din;
          ack_d   = 1'b1;
        end
      end
      OP_POP: begin
        if (isEmpty) begin
          udf_d = 1'b1;
        end else if (count_q == COUNT_ONE) begin
          count_d = COUNT_ZERO;
          top_d   = '0;
          ack_d   = 1'b1;
        end else begin
          count_d = count_q - COUNT_ONE;
          top_d   = stack_q[belowAddr];
          ack_d   = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (isEmpty) begin
          udf_d = 1'b1;
        end else begin
          wrEn   = 1'b1;
          wrAddr = topAddr;
          top_d  = din;
          ack_d  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= COUNT_ZERO;
      top_q   <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage keeps its contents through reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (wrEn && reset) begin
      stack_q[wrAddr] <= din;
    end
  end

  assign top   = top_q;
  assign count = count_q;
  assign empty = isEmpty;
  assign full  = isFull;
  assign ack   = ack_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Drives both growth directions of stack_engine with identical stimulus and
// checks every output against a queue-based reference stack.
module tb_stack_engine;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             reset;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             clr_err;

  logic [WIDTH-1:0] topDown,   topUp;
  logic [AW:0]      countDown, countUp;
  logic             emptyDown, emptyUp;
  logic             fullDown,  fullUp;
  logic             ackDown,   ackUp;
  logic             ovfDown,   ovfUp;
  logic             udfDown,   udfUp;

  int testsRun;
  int testsFailed;

  logic [WIDTH-1:0] modelStack [$];
  logic             modelAck;
  logic             modelOvf;
  logic             modelUdf;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GROW_DOWN(1'b1)) dutDown (
    .clk(clk), .reset(reset), .op(op), .din(din), .clr_err(clr_err),
    .top(topDown), .count(countDown), .empty(emptyDown), .full(fullDown),
    .ack(ackDown), .ovf(ovfDown), .udf(udfDown)
  );

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GROW_DOWN(1'b0)) dutUp (
    .clk(clk), .reset(reset), .op(op), .din(din), .clr_err(clr_err),
    .top(topUp), .count(countUp), .empty(emptyUp), .full(fullUp),
    .ack(ackUp), .ovf(ovfUp), .udf(udfUp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string step);
    logic [WIDTH-1:0] expTop;
    int               expCount;
    expCount = modelStack.size();
    expTop   = (expCount != 0) ? modelStack[expCount-1] : '0;
    checkOutput({step, " down.top"},   32'(topDown),   32'(expTop));
    checkOutput({step, " down.count"}, 32'(countDown), 32'(expCount));
    checkOutput({step, " down.empty"}, 32'(emptyDown), 32'(expCount == 0));
    checkOutput({step, " down.full"},  32'(fullDown),  32'(expCount == DEPTH));
    checkOutput({step, " down.ack"},   32'(ackDown),   32'(modelAck));
    checkOutput({step, " down.ovf"},   32'(ovfDown),   32'(modelOvf));
    checkOutput({step, " down.udf"},   32'(udfDown),   32'(modelUdf));
    checkOutput({step, " up.top"},     32'(topUp),     32'(expTop));
    checkOutput({step, " up.count"},   32'(countUp),   32'(expCount));
    checkOutput({step, " up.empty"},   32'(emptyUp),   32'(expCount == 0));
    checkOutput({step, " up.full"},    32'(fullUp),    32'(expCount == DEPTH));
    checkOutput({step, " up.ack"},     32'(ackUp),     32'(modelAck));
    checkOutput({step, " up.ovf"},     32'(ovfUp),     32'(modelOvf));
    checkOutput({step, " up.udf"},     32'(udfUp),     32'(modelUdf));
  endtask

  // Reference stack: the queue's back is the top of stack.
  task automatic updateModel(input logic [1:0] opV, input logic [WIDTH-1:0] dinV,
                             input logic clrV, input logic rstV);
    if (!rstV) begin
      modelStack.delete();
      modelAck = 1'b0;
      modelOvf = 1'b0;
      modelUdf = 1'b0;
    end else begin
      modelAck = 1'b0;
      if (clrV) begin
        modelOvf = 1'b0;
        modelUdf = 1'b0;
      end
      case (opV)
        2'd1: begin
          if (modelStack.size() < DEPTH) begin
            modelStack.push_back(dinV);
            modelAck = 1'b1;
          end else begin
            modelOvf = 1'b1;
          end
        end
        2'd2: begin
          if (modelStack.size() == 0) begin
            modelUdf = 1'b1;
          end else begin
            void'(modelStack.pop_back());
            modelAck = 1'b1;
          end
        end
        2'd3: begin
          if (modelStack.size() == 0) begin
            modelUdf = 1'b1;
          end else begin
            modelStack[modelStack.size()-1] = dinV;
            modelAck = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input string step, input logic [1:0] opV, input logic [WIDTH-1:0] dinV,
                               input logic clrV, input logic rstV);
    op      = opV;
    din     = dinV;
    clr_err = clrV;
    reset   = rstV;
    updateModel(opV, dinV, clrV, rstV);
    @(posedge clk);
    #1;
    checkAll(step);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelAck    = 1'b0;
    modelOvf    = 1'b0;
    modelUdf    = 1'b0;
    op          = 2'd0;
    din         = '0;
    clr_err     = 1'b0;
    reset       = 1'b0;

    applyStimulus("reset0", 2'd0, 16'h0000, 1'b0, 1'b0);
    applyStimulus("reset1", 2'd1, 16'hDEAD, 1'b1, 1'b0);

    applyStimulus("push1", 2'd1, 16'h1111, 1'b0, 1'b1);
    applyStimulus("push2", 2'd1, 16'h2222, 1'b0, 1'b1);
    applyStimulus("push3", 2'd1, 16'h3333, 1'b0, 1'b1);
    applyStimulus("push4", 2'd1, 16'h4444, 1'b0, 1'b1);
    checkOutput("fill down.top const", 32'(topDown), 32'h4444);
    checkOutput("fill up.full const",  32'(fullUp),  32'h1);

    applyStimulus("pushFull", 2'd1, 16'h5555, 1'b0, 1'b1);
    checkOutput("ovf down const", 32'(ovfDown), 32'h1);
    applyStimulus("popA", 2'd2, 16'h0000, 1'b0, 1'b1);
    checkOutput("pop down.top const", 32'(topDown), 32'h3333);
    applyStimulus("popB", 2'd2, 16'h0000, 1'b0, 1'b1);
    applyStimulus("popC", 2'd2, 16'h0000, 1'b0, 1'b1);
    applyStimulus("popD", 2'd2, 16'h0000, 1'b0, 1'b1);
    applyStimulus("popEmpty", 2'd2, 16'h0000, 1'b0, 1'b1);
    checkOutput("udf up const", 32'(udfUp), 32'h1);

    applyStimulus("replEmpty", 2'd3, 16'h9999, 1'b0, 1'b1);
    applyStimulus("pushA", 2'd1, 16'hAAAA, 1'b0, 1'b1);
    applyStimulus("replB", 2'd3, 16'hBBBB, 1'b0, 1'b1);
    checkOutput("repl up.top const", 32'(topUp), 32'hBBBB);
    applyStimulus("popLast", 2'd2, 16'h0000, 1'b0, 1'b1);

    applyStimulus("fill1", 2'd1, 16'hC001, 1'b0, 1'b1);
    applyStimulus("fill2", 2'd1, 16'hC002, 1'b0, 1'b1);
    applyStimulus("fill3", 2'd1, 16'hC003, 1'b0, 1'b1);
    applyStimulus("fill4", 2'd1, 16'hC004, 1'b0, 1'b1);
    applyStimulus("fillOvf", 2'd1, 16'hC005, 1'b0, 1'b1);
    applyStimulus("clrWithPush", 2'd1, 16'hC006, 1'b1, 1'b1);
    checkOutput("clr down.ovf kept", 32'(ovfDown), 32'h1);
    checkOutput("clr down.udf cleared", 32'(udfDown), 32'h0);
    applyStimulus("clrAlone", 2'd0, 16'h0000, 1'b1, 1'b1);
    checkOutput("clr up.ovf cleared", 32'(ovfUp), 32'h0);

    applyStimulus("popTo3", 2'd2, 16'h0000, 1'b0, 1'b1);
    applyStimulus("popTo2", 2'd2, 16'h0000, 1'b0, 1'b1);
    applyStimulus("resetPush", 2'd1, 16'h7777, 1'b0, 1'b0);
    checkOutput("reset down.count const", 32'(countDown), 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [1:0]       rOp;
      logic [WIDTH-1:0] rDin;
      logic             rClr;
      logic             rRst;
      rOp  = 2'($urandom_range(0, 3));
      rDin = WIDTH'($urandom);
      rClr = ($urandom_range(0, 9) == 0);
      rRst = ($urandom_range(0, 49) != 0);
      applyStimulus("random", rOp, rDin, rClr, rRst);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
